// File: rtl/ex_result_stage.sv
// ex_result_stage: 2-entry in-order result skid buffer between the ALU and MEM stages, with the architectural CC register
module ex_result_stage #(
    parameter int         DATA_W  = 16,
    parameter logic [2:0] CC_INIT = 3'b010
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_res,
    input  logic [2:0]        in_dr,
    input  logic              in_ld_reg,
    input  logic              in_ld_cc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_res,
    output logic [2:0]        out_dr,
    output logic              out_ld_reg,
    output logic              out_ld_cc,
    output logic [2:0]        out_nzp,
    output logic [2:0]        cc
);
    localparam int EW = DATA_W + 8;
    logic [EW-1:0] mem_q [2];
    logic [EW-1:0] mem_d [2];
    logic          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q, count_d;
    logic [2:0]    cc_q, cc_d;
    logic          push, pop;
    logic [2:0]    in_nzp;
    assign in_ready  = count_q != 2'd2;
    assign out_valid = count_q != 2'd0;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign in_nzp    = {in_res[DATA_W-1], ~|in_res, ~in_res[DATA_W-1] & |in_res};
    assign {out_res, out_dr, out_ld_reg, out_ld_cc, out_nzp} = out_valid ? mem_q[rd_ptr_q] : '0;
    assign cc        = cc_q;
    always_comb begin
        mem_d[0] = (push && !wr_ptr_q) ? {in_res, in_dr, in_ld_reg, in_ld_cc, in_nzp} : mem_q[0];
        mem_d[1] = (push && wr_ptr_q) ? {in_res, in_dr, in_ld_reg, in_ld_cc, in_nzp} : mem_q[1];
        wr_ptr_d = flush ? 1'b0 : wr_ptr_q ^ push;
        rd_ptr_d = flush ? 1'b0 : rd_ptr_q ^ pop;
        count_d  = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        cc_d     = (pop && out_ld_cc) ? out_nzp : cc_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            cc_q     <= CC_INIT;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cc_q     <= cc_d;
        end
    end
endmodule
